// File: rtl/pulse_seq_pkg.sv
//------------------------------------------------------------------------------
// pulse_seq_pkg
// Row field layout, note base table and FSM state type for pulse_sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pulse_seq_pkg;

  localparam int HOLD_BIT        = 7;
  localparam int OCT_MSB         = 6;
  localparam int OCT_LSB         = 4;
  localparam int SEMI_MSB        = 3;
  localparam int SEMI_LSB        = 0;
  localparam int FIRST_REST_SEMI = 12;

  // Octave-0 increments, A (semitone 9) anchored at 1024.
  localparam logic [11:0] NOTE_BASE [12] = '{
    12'd609, 12'd645, 12'd683, 12'd724, 12'd767,  12'd813,
    12'd861, 12'd912, 12'd967, 12'd1024, 12'd1085, 12'd1149
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  function automatic logic [11:0] note_base(input logic [3:0] semi);
    case (semi)
      4'd0:    note_base = NOTE_BASE[0];
      4'd1:    note_base = NOTE_BASE[1];
      4'd2:    note_base = NOTE_BASE[2];
      4'd3:    note_base = NOTE_BASE[3];
      4'd4:    note_base = NOTE_BASE[4];
      4'd5:    note_base = NOTE_BASE[5];
      4'd6:    note_base = NOTE_BASE[6];
      4'd7:    note_base = NOTE_BASE[7];
      4'd8:    note_base = NOTE_BASE[8];
      4'd9:    note_base = NOTE_BASE[9];
      4'd10:   note_base = NOTE_BASE[10];
      4'd11:   note_base = NOTE_BASE[11];
      default: note_base = 12'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_note_lut.sv
//------------------------------------------------------------------------------
// pulse_note_lut
// Combinational (semitone, octave) -> phase increment map with rest detection.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pulse_note_lut
  import pulse_seq_pkg::*;
#(
  parameter int PHASE_BITS = 18
) (
  input  logic [3:0]            semi,
  input  logic [2:0]            octave,
  output logic [PHASE_BITS-1:0] phase_inc,
  output logic                  is_rest
);

  // Wide enough for the largest base shifted by octave 7 before truncation.
  localparam int c_WIDE = (PHASE_BITS > 19) ? PHASE_BITS : 19;

  logic [c_WIDE-1:0] w_base_ext;

  always_comb begin
    w_base_ext = c_WIDE'(note_base(semi));
    phase_inc  = PHASE_BITS'(w_base_ext << octave);
    is_rest    = (semi >= 4'(FIRST_REST_SEMI));
  end

endmodule

`default_nettype wire

// File: rtl/pulse_sequencer.sv
//------------------------------------------------------------------------------
// pulse_sequencer
// Row-per-song-tick note sequencer feeding a pulse channel (trigger, gate,
// phase increment). Optional macro SEQ_TRANSPOSE_EN adds a saturating octave
// transpose input.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int PHASE_BITS  = 18,
  parameter int PATTERN_LEN = 16,
  parameter int GATE_TICKS  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick_clk,
  input  logic                           song_clk,
  input  logic                           run,
`ifdef SEQ_TRANSPOSE_EN
  input  logic [2:0]                     transpose,
`endif
  output logic [$clog2(PATTERN_LEN)-1:0] step_addr,
  input  logic [7:0]                     step_data,
  output logic                           note_on,
  output logic                           note_trigger,
  output logic [PHASE_BITS-1:0]          phase_inc,
  output logic                           loop_pulse
);

  localparam int c_AW = $clog2(PATTERN_LEN);
  localparam int c_GW = (GATE_TICKS < 1) ? 1 : $clog2(GATE_TICKS + 1);
  localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(PATTERN_LEN - 1);
  localparam logic [c_GW-1:0] c_GATE_LOAD = c_GW'(GATE_TICKS);

  seq_state_t            r_state;
  logic [c_GW-1:0]       r_gate_cnt;
  logic                  w_song_tick;
  logic                  w_hold;
  logic                  w_is_rest;
  logic [2:0]            w_octave;
  logic [PHASE_BITS-1:0] w_lut_phase;

  assign w_song_tick = tick_clk & song_clk;
  assign w_hold      = step_data[HOLD_BIT];

`ifdef SEQ_TRANSPOSE_EN
  logic [3:0] w_oct_sum;
  assign w_oct_sum = {1'b0, step_data[OCT_MSB:OCT_LSB]} + {1'b0, transpose};
  assign w_octave  = w_oct_sum[3] ? 3'd7 : w_oct_sum[2:0];
`else
  assign w_octave  = step_data[OCT_MSB:OCT_LSB];
`endif

  pulse_note_lut #(
    .PHASE_BITS (PHASE_BITS)
  ) u_note_lut (
    .semi      (step_data[SEMI_MSB:SEMI_LSB]),
    .octave    (w_octave),
    .phase_inc (w_lut_phase),
    .is_rest   (w_is_rest)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gate_cnt   <= '0;
      step_addr    <= '0;
      note_on      <= 1'b0;
      note_trigger <= 1'b0;
      phase_inc    <= '0;
      loop_pulse   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          step_addr    <= '0;
          note_on      <= 1'b0;
          note_trigger <= 1'b0;
          loop_pulse   <= 1'b0;
          r_gate_cnt   <= '0;
          if (run) r_state <= ST_RUN;
        end
        ST_RUN: begin
          loop_pulse <= 1'b0;
          if (!run) begin
            r_state      <= ST_IDLE;
            step_addr    <= '0;
            note_on      <= 1'b0;
            note_trigger <= 1'b0;
            r_gate_cnt   <= '0;
          end else if (w_song_tick) begin
            step_addr  <= (step_addr == c_LAST_ADDR) ? '0 : step_addr + c_AW'(1);
            loop_pulse <= (step_addr == c_LAST_ADDR);
            if (w_hold) begin
              // Tie: only an already sounding note gets its gate extended.
              note_trigger <= 1'b0;
              if (note_on) r_gate_cnt <= c_GATE_LOAD;
            end else if (w_is_rest) begin
              note_trigger <= 1'b0;
              note_on      <= 1'b0;
            end else begin
              note_trigger <= 1'b1;
              note_on      <= 1'b1;
              r_gate_cnt   <= c_GATE_LOAD;
              phase_inc    <= w_lut_phase;
            end
          end else if (tick_clk && note_on && (r_gate_cnt != '0)) begin
            r_gate_cnt <= r_gate_cnt - c_GW'(1);
            if ((r_gate_cnt == c_GW'(1)) && (GATE_TICKS != 0)) note_on <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pulse_sequencer.md
# pulse_sequencer

Row-based note sequencer that sits directly upstream of the pulse channel and drives its note_on, note_trigger and phase_inc inputs. The pattern is held externally (ROM or register file). The sequencer addresses it one row per song tick and decodes each row into a trigger pulse, a gate with programmable length, and an octave-scaled phase increment.

## Interface
- PHASE_BITS, 18, width of phase_inc; must match the channel.
- PATTERN_LEN, 16, rows per pattern; power of two, 2..256.
- GATE_TICKS, 3, tick_clk pulses note_on stays high after a trigger; 0 = gate never closes (legato).
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk.
- tick_clk  in  1  one-clk envelope tick strobe.
- song_clk  in  1  row qualifier; a song tick is a clk with tick_clk && song_clk.
- run  in  1  level; 1 = sequence, 0 = stop and rewind.
- step_addr  out  $clog2(PATTERN_LEN)  row address to pattern store.
- step_data  in  8  row contents for step_addr; combinational/async read.
- note_on  out  1  gate to channel.
- note_trigger  out  1  held high for a full row when the row is a new note.
- phase_inc  out  PHASE_BITS  oscillator increment to channel.
- loop_pulse  out  1  one-clk strobe when step_addr wraps to 0.

## Operation
- Row encoding: [7] = hold, [6:4] = octave o, [3:0] = semitone s.
- Hold flag set: tie. note_trigger=0, phase_inc unchanged, gate counter reloaded only if note_on=1.
- Hold clear, s ≤ 11: new note. note_trigger=1, note_on=1, gate counter=GATE_TICKS, phase_inc=(NOTE_BASE[s] << o) truncated to PHASE_BITS.
- Hold clear, s ≥ 12: rest. note_trigger=0, note_on=0, phase_inc unchanged.
- FSM states: IDLE and RUN.
  - IDLE: step_addr=0, note_on=0, note_trigger=0. Go to RUN when run=1.
  - RUN: on each song tick, register the decode of step_data and advance step_addr by 1.
  - RUN: step_addr wraps PATTERN_LEN-1 → 0; loop_pulse=1 on the wrap clk.
  - run=0 in RUN: go to IDLE on the next clk edge and clear the outputs in the same edge. phase_inc keeps its value.
- Gate countdown: on each tick_clk that is not a song tick, while note_on=1 and the counter is nonzero, decrement the counter. When the counter reaches 0 with GATE_TICKS ≠ 0, set note_on=0 on that same edge.
- A song tick always takes priority over the countdown in the same clk.

## Timing
- Reset values: step_addr=0, note_on=0, note_trigger=0, phase_inc=0, loop_pulse=0, state=IDLE, gate counter=0. Reset takes priority over all events, including mid-row.
- Row latency: the row at address A is decoded at song tick k. The channel consumes it at song tick k+1, when it samples note_trigger. note_trigger therefore stays valid across a whole row.
- All outputs are registered. step_addr changes only on song ticks, on leaving RUN, or on reset.
- The first song tick after entering RUN decodes row 0. step_addr is 1 afterwards.
- The PHASE_BITS truncation of the shifted value is silent; no saturation.

## Configuration
- SEQ_TRANSPOSE_EN defined: adds input transpose (3 bits, unsigned octaves).
  - Effective octave = min(o + transpose, 7), saturating.
  - transpose is sampled at each song tick.
- SEQ_TRANSPOSE_EN undefined: the port is absent and the octave is used as encoded.

## Structure
- Package pulse_seq_pkg holds:
  - NOTE_BASE[0..11], 12-bit constants: NOTE_BASE[9]=1024 and NOTE_BASE[s]=round(1024·2^((s−9)/12)), so NOTE_BASE[0]=609.
  - Row field constants: HOLD_BIT, OCT_MSB/LSB, SEMI_MSB/LSB, FIRST_REST_SEMI=12.
  - FSM state typedef.
- Sub-module pulse_note_lut: combinational map from (s, o) to phase_inc and an is_rest flag. It is instantiated once.

## Test plan
- Reset, then run=1 with row0=0x09 (o=0, A). After the first song tick: note_trigger=1, note_on=1, phase_inc=1024, step_addr=1.
- Row 0x30 (o=3, C): phase_inc=609<<3=4872. Next row 0x80 (hold): note_trigger=0, phase_inc stays 4872, note_on stays 1.
- GATE_TICKS=3, note row followed by 3 non-song tick_clk pulses: note_on falls on the 3rd pulse. With GATE_TICKS=0, note_on stays 1 indefinitely.
- Rest row 0x0C: note_on=0, note_trigger=0, phase_inc unchanged from the previous row.
- PATTERN_LEN=16, 16 song ticks: step_addr goes 15→0 and loop_pulse=1 for exactly one clk. run=0 mid-row: next clk step_addr=0, note_on=0. Assert rst_n=0 mid-gate: all outputs reach their reset values on the next edge.
- SEQ_TRANSPOSE_EN defined, transpose=5, row 0x59 (o=5): octave saturates to 7, phase_inc=1024<<7=131072.
